// File: rtl/cp0_io_system.sv
// CP0 exception/interrupt unit for the MEM stage, plus a word-only bridge to two countdown timers.
// int_req, cp0_rdata and bus reads are combinational; all state updates land on the clock edge.

module cp0_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_ctrl_i,
    input  logic        wr_preset_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  ctrl_o,
    output logic [31:0] preset_o,
    output logic [31:0] count_o,
    output logic        irq_o
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t      state_q;
    logic [3:0]  ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        flag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            flag_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (ctrl_q[0]) state_q <= LOAD;
                LOAD: begin
                    count_q <= (preset_q == 32'd0) ? 32'd1 : preset_q;
                    state_q <= CNT;
                end
                CNT: begin
                    if (!ctrl_q[0]) begin
                        state_q <= IDLE;
                    end else if (count_q > 32'd1) begin
                        count_q <= count_q - 32'd1;
                    end else begin
                        count_q <= 32'd0;
                        flag_q  <= 1'b1;
                        state_q <= INT;
                    end
                end
                INT: begin
                    // Mode 1 auto-reloads with a one-cycle flag; every other mode is one-shot.
                    if (ctrl_q[2:1] == 2'd1) flag_q <= 1'b0;
                    else                     ctrl_q[0] <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (wr_ctrl_i) begin
                ctrl_q <= wdata_i[3:0];
                flag_q <= 1'b0;
            end
            if (wr_preset_i) begin
                preset_q <= wdata_i;
                flag_q   <= 1'b0;
            end
        end
    end

    assign ctrl_o   = ctrl_q;
    assign preset_o = preset_q;
    assign count_o  = count_q;
    assign irq_o    = ctrl_q[3] & flag_q;
endmodule

module cp0_io_system #(
    parameter logic [31:0] PRID     = 32'h0000_0007,
    parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
    parameter logic [31:0] TC1_BASE = 32'h0000_7F10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  cp0_op,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic [4:0]  exc_code,
    input  logic        bd,
    input  logic [31:0] epc_in,
    input  logic        ext_int,
    output logic        int_req,
    output logic [31:0] epc_out,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [1:0]  bus_mode,
    output logic        bus_hit,
    output logic [31:0] bus_rdata,
    output logic [4:0]  bus_exc
);
    localparam logic [1:0] OP_MFC0 = 2'd1, OP_MTC0 = 2'd2, OP_ERET = 2'd3;
    localparam logic [1:0] BUS_RD = 2'd1, BUS_WR = 2'd2;

    logic [5:0]  sr_im_q;
    logic        sr_exl_q, sr_ie_q;
    logic        cause_bd_q;
    logic [5:0]  cause_ip_q;
    logic [4:0]  cause_exc_q;
    logic [31:0] epc_q;

    logic        tc0_irq, tc1_irq;
    logic [3:0]  tc0_ctrl, tc1_ctrl;
    logic [31:0] tc0_preset, tc1_preset, tc0_count, tc1_count;
    logic [5:0]  hw_int;
    logic        intr_pend;

    assign hw_int    = {3'b000, ext_int, tc1_irq, tc0_irq};
    assign intr_pend = sr_ie_q && (|(sr_im_q & hw_int));
    assign int_req   = !sr_exl_q && (intr_pend || (exc_code != 5'd0));
    assign epc_out   = epc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im_q     <= 6'd0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= 6'd0;
            cause_exc_q <= 5'd0;
            epc_q       <= 32'd0;
        end else begin
            cause_ip_q <= hw_int;
            if (int_req) begin
                sr_exl_q    <= 1'b1;
                cause_bd_q  <= bd;
                cause_exc_q <= intr_pend ? 5'd0 : exc_code;
                epc_q       <= (bd ? epc_in - 32'd4 : epc_in) & ~32'd3;
            end else if (cp0_op == OP_ERET) begin
                sr_exl_q <= 1'b0;
            end else if (cp0_op == OP_MTC0) begin
                if (cp0_addr == 5'd12) begin
                    sr_im_q  <= cp0_wdata[15:10];
                    sr_exl_q <= cp0_wdata[1];
                    sr_ie_q  <= cp0_wdata[0];
                end else if (cp0_addr == 5'd14) begin
                    epc_q <= cp0_wdata;
                end
            end
        end
    end

    always_comb begin
        cp0_rdata = 32'd0;
        if (cp0_op == OP_MFC0) begin
            case (cp0_addr)
                5'd12:   cp0_rdata = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
                5'd13:   cp0_rdata = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
                5'd14:   cp0_rdata = epc_q;
                5'd15:   cp0_rdata = PRID;
                default: cp0_rdata = 32'd0;
            endcase
        end
    end

    // Window decode: an unsigned offset below 12 means the address is inside that timer.
    logic [31:0] off0, off1;
    logic        hit0, hit1, misalign, wr_ok;
    logic [1:0]  word;
    logic [31:0] tc_word;

    assign off0     = bus_addr - TC0_BASE;
    assign off1     = bus_addr - TC1_BASE;
    assign hit0     = off0 < 32'd12;
    assign hit1     = off1 < 32'd12;
    assign bus_hit  = hit0 | hit1;
    assign word     = hit0 ? off0[3:2] : off1[3:2];
    assign misalign = bus_addr[1:0] != 2'b00;

    always_comb begin
        bus_exc = 5'd0;
        if (bus_hit) begin
            if (bus_mode == BUS_RD && misalign)                           bus_exc = 5'd4;
            else if (bus_mode == BUS_WR && (misalign || word == 2'd2))    bus_exc = 5'd5;
        end
    end

    always_comb begin
        tc_word = 32'd0;
        case (word)
            2'd0:    tc_word = hit0 ? {28'd0, tc0_ctrl} : {28'd0, tc1_ctrl};
            2'd1:    tc_word = hit0 ? tc0_preset : tc1_preset;
            2'd2:    tc_word = hit0 ? tc0_count  : tc1_count;
            default: tc_word = 32'd0;
        endcase
    end

    assign bus_rdata = (bus_hit && bus_mode == BUS_RD && bus_exc == 5'd0) ? tc_word : 32'd0;
    assign wr_ok     = bus_hit && bus_mode == BUS_WR && bus_exc == 5'd0 && !int_req;

    cp0_timer u_tc0 (
        .clk         (clk),
        .rst_n       (reset),
        .wr_ctrl_i   (wr_ok && hit0 && word == 2'd0),
        .wr_preset_i (wr_ok && hit0 && word == 2'd1),
        .wdata_i     (bus_wdata),
        .ctrl_o      (tc0_ctrl),
        .preset_o    (tc0_preset),
        .count_o     (tc0_count),
        .irq_o       (tc0_irq)
    );

    cp0_timer u_tc1 (
        .clk         (clk),
        .rst_n       (reset),
        .wr_ctrl_i   (wr_ok && hit1 && word == 2'd0),
        .wr_preset_i (wr_ok && hit1 && word == 2'd1),
        .wdata_i     (bus_wdata),
        .ctrl_o      (tc1_ctrl),
        .preset_o    (tc1_preset),
        .count_o     (tc1_count),
        .irq_o       (tc1_irq)
    );
endmodule

// File: tb/tb_cp0_io_system.sv
// Directed bench: stimulus pushes expected observations, a negedge monitor pops and compares.
module tb_cp0_io_system;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cp0_op;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata, cp0_rdata;
    logic [4:0]  exc_code;
    logic        bd;
    logic [31:0] epc_in;
    logic        ext_int;
    logic        int_req;
    logic [31:0] epc_out;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [1:0]  bus_mode;
    logic        bus_hit;
    logic [4:0]  bus_exc;

    cp0_io_system dut (
        .clk(clk), .reset(reset), .cp0_op(cp0_op), .cp0_addr(cp0_addr),
        .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .exc_code(exc_code), .bd(bd),
        .epc_in(epc_in), .ext_int(ext_int), .int_req(int_req), .epc_out(epc_out),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_mode(bus_mode),
        .bus_hit(bus_hit), .bus_rdata(bus_rdata), .bus_exc(bus_exc)
    );

    always #5 clk = ~clk;

    localparam int S_RDATA = 0, S_INTREQ = 1, S_EPC = 2, S_HIT = 3, S_BRDATA = 4, S_BEXC = 5;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    exp_t        mon_e;
    logic [31:0] mon_obs;
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            case (mon_e.sel)
                S_RDATA:  mon_obs = cp0_rdata;
                S_INTREQ: mon_obs = {31'd0, int_req};
                S_EPC:    mon_obs = epc_out;
                S_HIT:    mon_obs = {31'd0, bus_hit};
                S_BRDATA: mon_obs = bus_rdata;
                default:  mon_obs = {27'd0, bus_exc};
            endcase
            total++;
            if (mon_obs !== mon_e.val) begin
                bad++;
                $display("FAIL %s: got %h want %h", mon_e.name, mon_obs, mon_e.val);
            end
        end
    end

    task automatic chk(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name; e.sel = sel; e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        cp0_op = 2'd0; cp0_addr = 5'd0; cp0_wdata = 32'd0;
        exc_code = 5'd0; bd = 1'b0; epc_in = 32'd0; ext_int = 1'b0;
        bus_addr = 32'd0; bus_wdata = 32'd0; bus_mode = 2'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mfc0(input logic [4:0] a);
        cp0_op = 2'd1; cp0_addr = a;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_op = 2'd2; cp0_addr = a; cp0_wdata = d;
    endtask

    task automatic brd(input logic [31:0] a);
        bus_mode = 2'd1; bus_addr = a;
    endtask

    task automatic bwr(input logic [31:0] a, input logic [31:0] d);
        bus_mode = 2'd2; bus_addr = a; bus_wdata = d;
    endtask

    logic [31:0] t1_count [0:10] = '{0, 0, 2, 1, 0, 0, 0, 2, 1, 0, 0};
    logic [31:0] t1_cause [0:10] = '{0, 0, 0, 0, 0, 32'h800, 0, 0, 0, 0, 32'h800};

    initial begin
        idle();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Reset state
        idle(); mfc0(5'd12); brd(32'h7F00);
        chk("rst_sr", S_RDATA, 32'd0); chk("rst_intreq", S_INTREQ, 0);
        chk("rst_tc0_ctrl", S_BRDATA, 32'd0); chk("rst_epc_out", S_EPC, 32'd0);
        chk("rst_bus_exc", S_BEXC, 0); chk("rst_hit_tc0", S_HIT, 1);
        step();
        idle(); mfc0(5'd13); chk("rst_cause", S_RDATA, 32'd0); step();
        idle(); mfc0(5'd14); chk("rst_epc", S_RDATA, 32'd0); step();
        idle(); mfc0(5'd15); chk("prid", S_RDATA, 32'h7); step();

        // Exception in a delay slot; concurrent MTC0 and bus write must be dropped
        idle(); exc_code = 5'd10; bd = 1'b1; epc_in = 32'h3010;
        mtc0(5'd14, 32'hDEAD_BEEF); bwr(32'h7F04, 32'h55);
        chk("exc_intreq", S_INTREQ, 1);
        step();
        idle(); mfc0(5'd13);
        chk("exc_cause", S_RDATA, 32'h8000_0028); chk("exc_epc", S_EPC, 32'h300C);
        chk("exc_intreq_after", S_INTREQ, 0);
        step();
        idle(); mfc0(5'd12); brd(32'h7F04); exc_code = 5'd10;
        chk("exc_sr_exl", S_RDATA, 32'h2); chk("exc_wr_suppressed", S_BRDATA, 32'd0);
        chk("exc_masked_by_exl", S_INTREQ, 0);
        step();
        idle(); cp0_op = 2'd3; chk("eret_intreq", S_INTREQ, 0); step();
        idle(); mfc0(5'd12); chk("eret_sr", S_RDATA, 32'd0); chk("eret_epc_kept", S_EPC, 32'h300C); step();

        // External interrupt through IM bit 12
        idle(); mtc0(5'd12, 32'h1001); step();
        idle(); ext_int = 1'b1; epc_in = 32'h4006; mfc0(5'd12);
        chk("int_intreq", S_INTREQ, 1); chk("int_sr_old", S_RDATA, 32'h1001);
        step();
        idle(); ext_int = 1'b1; mfc0(5'd13);
        chk("int_exl_mask", S_INTREQ, 0); chk("int_cause", S_RDATA, 32'h1000);
        chk("int_epc", S_EPC, 32'h4004);
        step();
        idle(); cp0_op = 2'd3; ext_int = 1'b1; step();
        idle(); ext_int = 1'b1; mtc0(5'd12, 32'd0); chk("int_again", S_INTREQ, 1); step();
        idle(); mfc0(5'd12); chk("mtc0_discarded", S_RDATA, 32'h1003); step();
        idle(); mtc0(5'd12, 32'h0801); step();
        idle(); ext_int = 1'b1; mfc0(5'd12);
        chk("im_clear_intreq", S_INTREQ, 0); chk("sr_0801", S_RDATA, 32'h801);
        step();
        idle(); mtc0(5'd12, 32'd0); step();

        // Timer 0, one-shot with interrupt enable
        idle(); bwr(32'h7F04, 32'd3); step();
        idle(); bwr(32'h7F00, 32'h9); step();
        idle(); brd(32'h7F08); chk("tc0_cnt_e0", S_BRDATA, 32'd0); step();
        idle(); brd(32'h7F08); chk("tc0_cnt_e1", S_BRDATA, 32'd0); step();
        idle(); brd(32'h7F08); chk("tc0_cnt_e2", S_BRDATA, 32'd3); step();
        idle(); brd(32'h7F08); chk("tc0_cnt_e3", S_BRDATA, 32'd2); step();
        idle(); brd(32'h7F08); chk("tc0_cnt_e4", S_BRDATA, 32'd1); step();
        idle(); brd(32'h7F08); mfc0(5'd13);
        chk("tc0_cnt_e5", S_BRDATA, 32'd0); chk("tc0_ip_e5", S_RDATA, 32'd0);
        step();
        idle(); brd(32'h7F00); mfc0(5'd13);
        chk("tc0_ctrl_en_clr", S_BRDATA, 32'h8); chk("tc0_ip10", S_RDATA, 32'h400);
        step();
        idle(); bwr(32'h7F08, 32'h77);
        chk("wr_count_exc", S_BEXC, 5); chk("wr_count_hit", S_HIT, 1);
        step();
        idle(); brd(32'h7F08); mtc0(5'd12, 32'h0401);
        chk("wr_count_unchanged", S_BRDATA, 32'd0); chk("tc0_no_ie", S_INTREQ, 0);
        step();
        idle(); epc_in = 32'h5000; mfc0(5'd12);
        chk("tc0_intreq", S_INTREQ, 1); chk("sr_0401", S_RDATA, 32'h401);
        step();
        idle(); cp0_op = 2'd3; bwr(32'h7F00, 32'd0);
        chk("tc0_int_epc", S_EPC, 32'h5000); chk("tc0_int_exl", S_INTREQ, 0);
        step();
        idle(); mtc0(5'd12, 32'd0); chk("tc0_irq_cleared", S_INTREQ, 0); step();
        idle(); mfc0(5'd13); chk("tc0_ip_dropped", S_RDATA, 32'd0); step();

        // Bridge error and miss cases
        idle(); brd(32'h7F01);
        chk("rd_misalign_exc", S_BEXC, 4); chk("rd_misalign_hit", S_HIT, 1);
        step();
        idle(); brd(32'h7F20);
        chk("miss_hit", S_HIT, 0); chk("miss_rdata", S_BRDATA, 32'd0); chk("miss_exc", S_BEXC, 0);
        step();

        // Timer 1, periodic mode with reload
        idle(); bwr(32'h7F14, 32'd2); step();
        idle(); bwr(32'h7F10, 32'hB); step();
        for (int k = 0; k <= 10; k++) begin
            idle(); brd(32'h7F18); mfc0(5'd13);
            chk($sformatf("tc1_cnt_e%0d", k), S_BRDATA, t1_count[k]);
            chk($sformatf("tc1_ip_e%0d", k), S_RDATA, t1_cause[k]);
            step();
        end
        idle(); bwr(32'h7F10, 32'd0); step();

        idle();
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL monitor_drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
